// File: rtl/spi_tx_arbiter_pkg.sv
// Shared types and constants for the SPI transmit arbiter slice.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam int SPI_WIDTH = 8;
  localparam int SPI_DIV   = 17;

  // Ceiling log2, never narrower than one bit so single-value fields stay legal.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// Requester bus plus serial lane of the SPI transmit arbiter.
interface spi_tx_arbiter_if
  import spi_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = SPI_WIDTH
) ();

  localparam int ID_W = clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
  logic [N_REQ-1:0]       ack;
  logic                   mosi;
  logic                   cs_n;
  logic                   busy;
  logic [ID_W-1:0]        last_id;

  modport master (output req, data, input ack, mosi, cs_n, busy, last_id);
  modport slave  (input req, data, output ack, mosi, cs_n, busy, last_id);

endinterface

// File: rtl/spi_tx_arbiter_arbiter.sv
// Combinational round-robin pick: first set request after last_id, wrapping modulo N_REQ.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  int   idx;
  logic found;

  // Explicit subtract instead of % keeps the wrap correct for non-power-of-two N_REQ.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_id) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Shares one LSB-first serial lane between N_REQ byte producers with round-robin arbitration.
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = SPI_WIDTH,
  parameter int DIV   = SPI_DIV
) (
  input  logic            sclk,
  input  logic            reset,
  spi_tx_arbiter_if.slave bus
);

  localparam int ID_W  = clog2(N_REQ);
  localparam int DIV_W = clog2(DIV);
  localparam int CNT_W = clog2(WIDTH);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] divider, divider_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [WIDTH-1:0] shift, shift_nxt, win_data;
  logic             cs_n, cs_n_nxt;
  logic [N_REQ-1:0] ack, ack_nxt, gnt;
  logic [ID_W-1:0]  last_id, last_id_nxt, gnt_id;
  logic             tick;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .en      (state == IDLE),
    .req     (bus.req),
    .last_id (last_id),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) win_data = win_data | bus.data[i*WIDTH +: WIDTH];
    end
  end

  assign tick = (divider == DIV_W'(DIV - 1));

  // The shifter is cleared on leaving SHIFT, so its LSB doubles as the registered mosi.
  always_comb begin
    state_nxt   = state;
    divider_nxt = '0;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    cs_n_nxt    = cs_n;
    ack_nxt     = '0;
    last_id_nxt = last_id;
    case (state)
      IDLE: begin
        if (|gnt) begin
          ack_nxt     = gnt;
          shift_nxt   = win_data;
          last_id_nxt = gnt_id;
          cs_n_nxt    = 1'b0;
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        divider_nxt = tick ? '0 : divider + 1'b1;
        if (tick) begin
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            state_nxt = GAP;
            cs_n_nxt  = 1'b1;
            shift_nxt = '0;
          end else begin
            shift_nxt   = shift >> 1;
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        divider_nxt = tick ? '0 : divider + 1'b1;
        if (tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!reset) begin
      state   <= IDLE;
      divider <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      cs_n    <= 1'b1;
      ack     <= '0;
      last_id <= ID_W'(N_REQ - 1);
    end else begin
      state   <= state_nxt;
      divider <= divider_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      cs_n    <= cs_n_nxt;
      ack     <= ack_nxt;
      last_id <= last_id_nxt;
    end
  end

  assign bus.ack     = ack;
  assign bus.mosi    = shift[0];
  assign bus.cs_n    = cs_n;
  assign bus.busy    = (state != IDLE);
  assign bus.last_id = last_id;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: default build (4 req, DIV 17) and a small corner build (3 req, DIV 2).
module tb_spi_tx_arbiter;
  import spi_pkg::*;

  localparam int W = 8;

  logic       sclk  = 1'b0;
  logic       reset = 1'b0;
  logic       sel   = 1'b0;
  logic [3:0] req_v = '0;
  logic [7:0] byte_v [4];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_last = 3;
  int last_ack_cyc = 0;
  int n_cur = 4;
  int div_cur = 17;

  spi_tx_arbiter_if #(.N_REQ(4), .WIDTH(W)) bus_a ();
  spi_tx_arbiter_if #(.N_REQ(3), .WIDTH(W)) bus_b ();

  spi_tx_arbiter #(.N_REQ(4), .WIDTH(W), .DIV(17)) dut_a (
    .sclk(sclk), .reset(reset), .bus(bus_a.slave));
  spi_tx_arbiter #(.N_REQ(3), .WIDTH(W), .DIV(2)) dut_b (
    .sclk(sclk), .reset(reset), .bus(bus_b.slave));

  assign bus_a.req  = sel ? 4'b0 : req_v;
  assign bus_a.data = {byte_v[3], byte_v[2], byte_v[1], byte_v[0]};
  assign bus_b.req  = sel ? req_v[2:0] : 3'b0;
  assign bus_b.data = {byte_v[2], byte_v[1], byte_v[0]};

  logic [3:0] obs_ack;
  logic       obs_mosi, obs_cs_n, obs_busy;
  logic [1:0] obs_last;
  assign obs_ack  = sel ? {1'b0, bus_b.ack} : bus_a.ack;
  assign obs_mosi = sel ? bus_b.mosi : bus_a.mosi;
  assign obs_cs_n = sel ? bus_b.cs_n : bus_a.cs_n;
  assign obs_busy = sel ? bus_b.busy : bus_a.busy;
  assign obs_last = sel ? bus_b.last_id : bus_a.last_id;

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic [31:0] bytes);
    req_v = r;
    for (int i = 0; i < 4; i++) byte_v[i] = bytes[i*8 +: 8];
  endtask

  // Reference arbitration: first requester after the previous winner, wrapping modulo n.
  function automatic int model_winner(input logic [3:0] r);
    for (int k = 1; k <= n_cur; k++) begin
      if (r[(model_last + k) % n_cur]) return (model_last + k) % n_cur;
    end
    return -1;
  endfunction

  // Expected {ack, cs_n, mosi, busy} t cycles after the grant edge.
  function automatic logic [6:0] wave(input int t, input int id, input logic [7:0] b);
    logic [3:0] a;
    a = (t == 0) ? 4'(1 << id) : 4'b0;
    if (t < W * div_cur) return {a, 1'b0, b[t / div_cur], 1'b1};
    if (t < (W + 1) * div_cur) return {a, 3'b101};
    return {a, 3'b100};
  endfunction

  task automatic run_frame(input logic [3:0] drop_mask, input bit drop_win,
                           input int n_check, input bit chk_spacing);
    int id;
    int waited;
    logic [7:0] b;
    id = model_winner(req_v);
    if (id < 0) id = 0;
    b = byte_v[id];
    waited = 0;
    do begin
      @(negedge sclk);
      waited++;
    end while (obs_ack == 4'b0 && waited < 400);
    if (obs_ack == 4'b0) begin
      check_output("ack_timeout", 32'(obs_ack), 32'(1 << id));
      return;
    end
    check_output("last_id", 32'(obs_last), id);
    if (chk_spacing) check_output("ack_spacing", cyc - last_ack_cyc, (W + 1) * div_cur + 1);
    last_ack_cyc = cyc;
    model_last = id;
    req_v = req_v & ~drop_mask;
    if (drop_win) req_v[id] = 1'b0;
    for (int t = 0; t <= n_check; t++) begin
      if (t > 0) @(negedge sclk);
      check_output($sformatf("wave id=%0d t=%0d", id, t),
                   32'({obs_ack, obs_cs_n, obs_mosi, obs_busy}), 32'(wave(t, id, b)));
    end
  endtask

  task automatic check_idle_reset(input int exp_last);
    check_output("rst_ack", 32'(obs_ack), 32'h0);
    check_output("rst_cs_n", 32'(obs_cs_n), 32'h1);
    check_output("rst_mosi", 32'(obs_mosi), 32'h0);
    check_output("rst_busy", 32'(obs_busy), 32'h0);
    check_output("rst_last_id", 32'(obs_last), exp_last);
  endtask

  initial begin
    int full;
    for (int i = 0; i < 4; i++) byte_v[i] = 8'h00;
    full = (W + 1) * 17;

    // Reset, then single request of A5
    repeat (3) @(negedge sclk);
    check_idle_reset(3);
    reset = 1'b1;
    apply_stimulus(4'b0001, 32'h0000_00A5);
    run_frame(4'b0001, 1'b0, full, 1'b0);

    // Round-robin fairness from a fresh pointer
    reset = 1'b0;
    @(negedge sclk);
    reset = 1'b1;
    model_last = 3;
    apply_stimulus(4'b1111, 32'h1312_1110);
    for (int f = 0; f < 5; f++) run_frame((f == 4) ? 4'hF : 4'h0, 1'b0, full, f > 0);

    // Rotation skip
    apply_stimulus(4'b0010, $urandom());
    run_frame(4'h0, 1'b1, full, 1'b0);
    apply_stimulus(4'b1001, $urandom());
    run_frame(4'h0, 1'b1, full, 1'b0);
    run_frame(4'h0, 1'b1, full, 1'b1);
    apply_stimulus(4'b0100, $urandom());
    run_frame(4'h0, 1'b1, full, 1'b0);
    apply_stimulus(4'b0100, $urandom());
    run_frame(4'h0, 1'b1, full, 1'b0);

    // Busy masking: req[2] pulses and withdraws while another frame shifts
    apply_stimulus(4'b0001, $urandom());
    fork
      run_frame(4'h0, 1'b1, full, 1'b0);
      begin
        repeat (40) @(negedge sclk);
        req_v[2] = 1'b1;
        repeat (30) @(negedge sclk);
        req_v[2] = 1'b0;
      end
    join
    for (int i = 0; i < 20; i++) begin
      @(negedge sclk);
      check_output("no_late_ack", 32'(obs_ack), 32'h0);
    end

    // Mid-frame reset inside bit 4 of FF
    apply_stimulus(4'b0001, 32'h0000_00FF);
    run_frame(4'h0, 1'b1, 4 * 17 + 2, 1'b0);
    reset = 1'b0;
    @(negedge sclk);
    check_idle_reset(3);
    reset = 1'b1;
    model_last = 3;
    apply_stimulus(4'b0001, 32'h0000_005A);
    run_frame(4'h0, 1'b1, full, 1'b0);

    // Randomized request mix with held losers
    req_v = '0;
    for (int i = 0; i < 4; i++) byte_v[i] = 8'($urandom());
    for (int it = 0; it < 8; it++) begin
      req_v = req_v | 4'($urandom_range(1, 15));
      byte_v[$urandom_range(0, 3)] = 8'($urandom());
      run_frame(4'h0, 1'b1, full, 1'b0);
    end
    req_v = '0;

    // Corner build: 3 requesters, DIV 2
    sel = 1'b1;
    n_cur = 3;
    div_cur = 2;
    reset = 1'b0;
    repeat (2) @(negedge sclk);
    check_idle_reset(2);
    reset = 1'b1;
    model_last = 2;
    apply_stimulus(4'b0111, 32'h0023_2221);
    for (int f = 0; f < 4; f++) run_frame((f == 3) ? 4'hF : 4'h0, 1'b0, (W + 1) * 2, f > 0);
    for (int it = 0; it < 10; it++) begin
      req_v = req_v | 4'($urandom_range(1, 7));
      byte_v[$urandom_range(0, 2)] = 8'($urandom());
      run_frame(4'h0, 1'b1, (W + 1) * 2, 1'b0);
    end
    req_v = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
- Shares one serial transmit lane (mosi plus frame select) between N_REQ byte producers.
- Each requester presents a byte and a request; round-robin arbitration picks one.
- The winner's byte is serialized LSB-first at a divided bit rate inside a cs_n-framed window, followed by a one-bit-period gap.
- Sits between on-chip producers (counters, status sources) and the off-chip serial link.

Parameters:
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 8, bits per frame
- DIV, 17, sclk cycles per serial bit (≥2)

Ports:
- sclk, input, 1, system clock, all logic on posedge
- reset, input, 1, synchronous active-low reset
- req, input, N_REQ, per-requester transfer request, level
- data, input, N_REQ*WIDTH, requester i byte at data[i*WIDTH +: WIDTH]
- ack, output, N_REQ, one-cycle grant/accept pulse, one-hot
- mosi, output, 1, serial data, LSB first
- cs_n, output, 1, frame select, low during the data bits
- busy, output, 1, high whenever state != IDLE
- last_id, output, clog2(N_REQ), index of the most recent winner

Behaviour:
- Clock and reset: one clock, sclk; reset is synchronous, active-low. Reset is sampled on a sclk posedge.
- Reset values: state=IDLE, ack=0, mosi=0, cs_n=1, busy=0, last_id=N_REQ-1 (so req[0] wins first), divider=0, bit_cnt=0, shift=0.
- FSM states: IDLE, SHIFT, GAP.
- IDLE, req==0: hold. mosi=0, cs_n=1.
- IDLE, req!=0 at edge k, all of the following take effect after edge k:
  - winner = first set req scanning last_id+1, last_id+2, ... modulo N_REQ
  - ack[winner]=1 for exactly that one cycle
  - shift<=data[winner]; last_id<=winner
  - cs_n<=0; mosi=data[winner][0]
  - divider<=0; bit_cnt<=0; state<=SHIFT
- tick = (divider==DIV-1). The divider counts 0..DIV-1 and wraps in SHIFT and GAP; it is held at 0 in IDLE.
- SHIFT, on tick:
  - if bit_cnt==WIDTH-1: state<=GAP, cs_n<=1, mosi<=0
  - otherwise: shift right by 1, bit_cnt++, mosi<=next bit
  - each bit is therefore stable for exactly DIV cycles
- GAP: cs_n=1, mosi=0 for DIV cycles; on tick, state<=IDLE.
- Timing:
  - ack at edge k means IDLE is re-entered at edge k+(WIDTH+1)*DIV
  - earliest next ack is at edge k+(WIDTH+1)*DIV+1; default spacing is 154 cycles
  - mosi/cs_n are registered outputs; no combinational path from req/data
- Handshake:
  - Requester holds req and data stable until it sees ack; data is captured on the ack edge only.
  - A req dropped before ack is withdrawn with no transfer.
  - req still high in the cycle after ack counts as a new request for a later frame.
  - req is ignored outside IDLE.
- Simultaneous requests: exactly one winner per frame, with rotating priority. A continuously asserting requester cannot starve the others: with all N_REQ requesting, every index is served once per N_REQ frames.
- Reset mid-frame: the next edge forces all reset values, cs_n=1 immediately, and the partial frame is dropped without retransmission.
- Width rules:
  - divider width = clog2(DIV); bit_cnt width = clog2(WIDTH)
  - modulo-N_REQ pointer increment wraps N_REQ-1 -> 0, including when N_REQ is not a power of two
- ack is always one-hot or zero, never multi-hot.

Decomposition:
- Shared package (spi_pkg):
  - state enum {IDLE, SHIFT, GAP}
  - default constants SPI_WIDTH=8, SPI_DIV=17
  - clog2 helper
- One sub-module, rr_arbiter:
  - parameter N_REQ; inputs req, last_id, en
  - outputs gnt (one-hot) and gnt_id
  - purely combinational priority rotation; the top registers last_id and ack.
- Divider, bit counter and shifter stay in the top.

Test Plan:
1. Reset and single request. Reset low 3 cycles, then high; req=0001, data[0]=8'hA5 -> after first active edge: ack=0001 for 1 cycle, cs_n=0. mosi sequence 1,0,1,0,0,1,0,1 with each bit held 17 cycles. cs_n=1 for 17 cycles, then busy=0. Total busy 153 cycles.
2. Round-robin fairness. req=1111 held, data[i]=8'h10+i -> ack order 0,1,2,3,0. Serialized bytes 10,11,12,13,10. Ack spacing exactly 154 cycles.
3. Rotation skip. last_id=1, req=1001 -> winner 3, then winner 0 on the following frame. req=0100 alone after last_id=2 -> winner 2.
4. Busy masking and withdrawal. Pulse req[2] high during SHIFT of another frame, low before IDLE -> no ack[2] ever, and no change to the current frame.
5. Mid-frame reset. Assert reset at bit 4 of 8'hFF -> next edge cs_n=1, mosi=0, busy=0. After release, a new req=0001 is granted to index 0.
6. Parameter corner. DIV=2, WIDTH=8, N_REQ=3, req=111 -> ack spacing 19 cycles, order 0,1,2,0, and the pointer wraps 2->0.
